// File: rtl/bildpuffer_dual.sv
// Double-buffered frame buffer: drawing writes the back bank, scan-out reads the front bank,
// banks exchange on a vblank-qualified swap, and a clear engine fills the back bank.
//
// state | meaning
// IDLE  | drawing writes accepted, swaps may execute, a pending clear starts here
// CLEAR | one back-bank pixel per cycle is filled with the latched colour
module bildpuffer_dual #(
    parameter int WIDTH        = 160,
    parameter int HEIGHT       = 120,
    parameter int BITSPERPIXEL = 8,
    parameter int COORDBITS    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [COORDBITS-1:0]    x,
    input  logic [COORDBITS-1:0]    y,
    input  logic [BITSPERPIXEL-1:0] color,
    input  logic                    write,
    input  logic [COORDBITS-1:0]    x_data,
    input  logic [COORDBITS-1:0]    y_data,
    output logic [BITSPERPIXEL-1:0] pixelData,
    input  logic                    vblank,
    input  logic                    swap_req,
    output logic                    swap_done,
    input  logic                    clear_req,
    input  logic [BITSPERPIXEL-1:0] clear_color,
    output logic                    clear_done,
    output logic                    busy,
    output logic                    front_sel
);

    localparam int PIXELS = WIDTH * HEIGHT;
    localparam int AW     = $clog2(PIXELS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(PIXELS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state;
    logic                    swap_pend;
    logic                    clear_pend;
    logic [AW-1:0]           clr_cnt;
    logic [BITSPERPIXEL-1:0] clr_color;

    logic [BITSPERPIXEL-1:0] mem0 [PIXELS];
    logic [BITSPERPIXEL-1:0] mem1 [PIXELS];

    logic                    wr_ok;
    logic                    rd_ok;
    logic [AW-1:0]           wr_addr;
    logic [AW-1:0]           rd_addr;
    logic                    mem_we;
    logic [AW-1:0]           mem_waddr;
    logic [BITSPERPIXEL-1:0] mem_wdata;
    logic                    swap_fire;

    function automatic logic [AW-1:0] addr_of(input logic [COORDBITS-1:0] cx,
                                              input logic [COORDBITS-1:0] cy);
        return AW'(int'(cy) * WIDTH + int'(cx));
    endfunction

    assign wr_ok   = (int'(x) < WIDTH) && (int'(y) < HEIGHT);
    assign rd_ok   = (int'(x_data) < WIDTH) && (int'(y_data) < HEIGHT);
    assign wr_addr = addr_of(x, y);
    assign rd_addr = addr_of(x_data, y_data);

    assign busy      = clear_pend || (state == CLEAR);
    // A pending clear holds off an otherwise eligible swap
    assign swap_fire = swap_pend && vblank && (state == IDLE) && !clear_pend;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = color;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdata = clr_color;
        end else if (write && wr_ok) begin
            mem_we = 1'b1;
        end
    end

    // RAM is never reset; the back bank is the one not being displayed
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (front_sel) mem0[mem_waddr] <= mem_wdata;
            else           mem1[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixelData <= '0;
        end else if (rd_ok) begin
            pixelData <= front_sel ? mem1[rd_addr] : mem0[rd_addr];
        end else begin
            pixelData <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            front_sel  <= 1'b0;
            swap_pend  <= 1'b0;
            swap_done  <= 1'b0;
            clear_pend <= 1'b0;
            clear_done <= 1'b0;
            clr_cnt    <= '0;
            clr_color  <= '0;
        end else begin
            swap_done  <= 1'b0;
            clear_done <= 1'b0;

            if (swap_fire) begin
                front_sel <= ~front_sel;
                swap_pend <= 1'b0;
                swap_done <= 1'b1;
            end else if (swap_req) begin
                swap_pend <= 1'b1;
            end

            if (clear_req && !busy) begin
                clear_pend <= 1'b1;
                clr_color  <= clear_color;
            end

            case (state)
                IDLE: begin
                    if (clear_pend) begin
                        state      <= CLEAR;
                        clr_cnt    <= '0;
                        clear_pend <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state      <= IDLE;
                        clear_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bildpuffer_dual.sv
// Directed bench for bildpuffer_dual: reset, draw/read, range checks, swap merging,
// clear engine timing and reset abort.
module tb_bildpuffer_dual;

    localparam int PIXELS = 160 * 120;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] x, y, color, x_data, y_data, clear_color;
    logic       write, vblank, swap_req, clear_req;
    logic [7:0] pixelData;
    logic       swap_done, clear_done, busy, front_sel;

    int checks = 0;
    int errors = 0;

    bildpuffer_dual dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .color(color), .write(write),
        .x_data(x_data), .y_data(y_data), .pixelData(pixelData), .vblank(vblank),
        .swap_req(swap_req), .swap_done(swap_done), .clear_req(clear_req),
        .clear_color(clear_color), .clear_done(clear_done), .busy(busy),
        .front_sel(front_sel)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] cx, input logic [7:0] cy, input logic [7:0] c);
        x = cx; y = cy; color = c; write = 1'b1;
        step();
        write = 1'b0;
    endtask

    // Request then wait the one edge the swap needs; vblank held high throughout
    task automatic do_swap();
        swap_req = 1'b1; vblank = 1'b1;
        step();
        swap_req = 1'b0;
        step();
        vblank = 1'b0;
    endtask

    task automatic rd(input logic [7:0] cx, input logic [7:0] cy);
        x_data = cx; y_data = cy;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; x = 0; y = 0; color = 0; write = 0; x_data = 0; y_data = 0;
        vblank = 0; swap_req = 0; clear_req = 0; clear_color = 0;
        step(); step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({pixelData, front_sel, busy, swap_done, clear_done} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: pix=%h fs=%b busy=%b sd=%b cd=%b, required all 0",
                     pixelData, front_sel, busy, swap_done, clear_done);
        end
    endtask

    task automatic test_write_swap_read();
        wr(8'd3, 8'd2, 8'h5A);
        swap_req = 1'b1; vblank = 1'b1;
        step();
        swap_req = 1'b0;
        checks++;
        if (front_sel !== 1'b0 || swap_done !== 1'b0) begin
            errors++;
            $display("FAIL swap_early: fs=%b sd=%b, required 0 0", front_sel, swap_done);
        end
        step();
        checks++;
        if (swap_done !== 1'b1 || front_sel !== 1'b1) begin
            errors++;
            $display("FAIL swap_exec: sd=%b fs=%b, required 1 1", swap_done, front_sel);
        end
        step();
        vblank = 1'b0;
        checks++;
        if (swap_done !== 1'b0) begin
            errors++;
            $display("FAIL swap_done_width: sd=%b, required 0", swap_done);
        end
        rd(8'd3, 8'd2);
        checks++;
        if (pixelData !== 8'h5A) begin
            errors++;
            $display("FAIL read_3_2: got %h, required 5a", pixelData);
        end
    endtask

    task automatic test_out_of_range();
        // back is bank 0; (160,5) would alias (0,6) if unguarded
        wr(8'd0, 8'd6, 8'h33);
        wr(8'd5, 8'd119, 8'h22);
        wr(8'd160, 8'd5, 8'hFF);
        wr(8'd5, 8'd120, 8'hFF);
        do_swap();
        checks++;
        if (front_sel !== 1'b0) begin
            errors++;
            $display("FAIL oor_swap: fs=%b, required 0", front_sel);
        end
        rd(8'd0, 8'd6);
        checks++;
        if (pixelData !== 8'h33) begin
            errors++;
            $display("FAIL oor_alias_0_6: got %h, required 33", pixelData);
        end
        rd(8'd5, 8'd119);
        checks++;
        if (pixelData !== 8'h22) begin
            errors++;
            $display("FAIL oor_5_119: got %h, required 22", pixelData);
        end
        rd(8'd160, 8'd0);
        checks++;
        if (pixelData !== 8'h00) begin
            errors++;
            $display("FAIL oor_read_x: got %h, required 00", pixelData);
        end
        rd(8'd5, 8'd119);
        rd(8'd5, 8'd120);
        checks++;
        if (pixelData !== 8'h00) begin
            errors++;
            $display("FAIL oor_read_y: got %h, required 00", pixelData);
        end
    endtask

    task automatic test_swap_merge();
        int bad = 0;
        int pulses = 0;
        swap_req = 1'b1; vblank = 1'b0;
        step();
        swap_req = 1'b0;
        for (int i = 0; i < 50; i++) begin
            swap_req = (i == 10 || i == 20);
            step();
            if (front_sel !== 1'b0 || swap_done !== 1'b0) bad++;
        end
        swap_req = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL swap_no_vblank: %0d bad cycles, required 0", bad);
        end
        vblank = 1'b1;
        step();
        checks++;
        if (front_sel !== 1'b1 || swap_done !== 1'b1) begin
            errors++;
            $display("FAIL swap_on_vblank: fs=%b sd=%b, required 1 1", front_sel, swap_done);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (swap_done === 1'b1) pulses++;
        end
        vblank = 1'b0;
        checks++;
        if (pulses != 0 || front_sel !== 1'b1) begin
            errors++;
            $display("FAIL swap_merge: extra pulses=%0d fs=%b, required 0 1", pulses, front_sel);
        end
    endtask

    task automatic test_clear();
        int cnt = 0;
        int cd_pulses = 0;
        clear_color = 8'h11; clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_busy_rise: busy=%b, required 1", busy);
        end
        // pending cycle plus PIXELS CLEAR cycles; draw writes and a re-request must be dropped
        while (busy === 1'b1 && cnt < 30000) begin
            x = 8'(cnt % 160); y = 8'(cnt % 120); color = 8'hEE; write = 1'b1;
            clear_req = (cnt == 500); clear_color = (cnt == 500) ? 8'h77 : 8'h11;
            cnt++;
            if (clear_done === 1'b1) cd_pulses++;
            step();
        end
        write = 1'b0; clear_req = 1'b0;
        checks++;
        if (cnt != PIXELS + 1) begin
            errors++;
            $display("FAIL clear_busy_len: busy cycles %0d, required %0d", cnt, PIXELS + 1);
        end
        checks++;
        if (clear_done !== 1'b1 || busy !== 1'b0 || cd_pulses != 0) begin
            errors++;
            $display("FAIL clear_done_pulse: cd=%b busy=%b early=%0d, required 1 0 0",
                     clear_done, busy, cd_pulses);
        end
        step();
        checks++;
        if (clear_done !== 1'b0) begin
            errors++;
            $display("FAIL clear_done_width: cd=%b, required 0", clear_done);
        end
        do_swap();
        rd(8'd0, 8'd0);
        checks++;
        if (pixelData !== 8'h11) begin
            errors++;
            $display("FAIL clear_0_0: got %h, required 11", pixelData);
        end
        rd(8'd159, 8'd119);
        checks++;
        if (pixelData !== 8'h11) begin
            errors++;
            $display("FAIL clear_159_119: got %h, required 11", pixelData);
        end
        rd(8'd80, 8'd60);
        checks++;
        if (pixelData !== 8'h11) begin
            errors++;
            $display("FAIL clear_80_60: got %h, required 11", pixelData);
        end
    endtask

    task automatic test_swap_during_clear();
        int cnt = 0;
        int bad = 0;
        clear_color = 8'h44; clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        swap_req = 1'b1; vblank = 1'b1;
        step();
        swap_req = 1'b0;
        while (busy === 1'b1 && cnt < 30000) begin
            if (front_sel !== 1'b0 || swap_done !== 1'b0) bad++;
            cnt++;
            step();
        end
        checks++;
        if (bad != 0 || clear_done !== 1'b1 || front_sel !== 1'b0) begin
            errors++;
            $display("FAIL swap_held_by_clear: bad=%0d cd=%b fs=%b, required 0 1 0",
                     bad, clear_done, front_sel);
        end
        step();
        vblank = 1'b0;
        checks++;
        if (swap_done !== 1'b1 || front_sel !== 1'b1) begin
            errors++;
            $display("FAIL swap_after_clear: sd=%b fs=%b, required 1 1", swap_done, front_sel);
        end
        rd(8'd10, 8'd10);
        checks++;
        if (pixelData !== 8'h44) begin
            errors++;
            $display("FAIL clear2_10_10: got %h, required 44", pixelData);
        end
    endtask

    task automatic test_reset_abort();
        int cd_pulses = 0;
        clear_color = 8'h99; clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        // addresses 0..998 of bank 0 get filled before the abort
        repeat (1000) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || front_sel !== 1'b0 || pixelData !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: busy=%b fs=%b pix=%h, required 0 0 00",
                     busy, front_sel, pixelData);
        end
        repeat (3) begin
            step();
            if (clear_done === 1'b1) cd_pulses++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            step();
            if (clear_done === 1'b1 || busy === 1'b1) cd_pulses++;
        end
        checks++;
        if (cd_pulses != 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d bad cycles, required 0", cd_pulses);
        end
        wr(8'd7, 8'd7, 8'h5C);
        do_swap();
        checks++;
        if (front_sel !== 1'b1) begin
            errors++;
            $display("FAIL abort_swap: fs=%b, required 1", front_sel);
        end
        rd(8'd7, 8'd7);
        checks++;
        if (pixelData !== 8'h5C) begin
            errors++;
            $display("FAIL abort_rw: got %h, required 5c", pixelData);
        end
        do_swap();
        rd(8'd0, 8'd1);
        checks++;
        if (pixelData !== 8'h99) begin
            errors++;
            $display("FAIL abort_partial_lo: got %h, required 99", pixelData);
        end
        rd(8'd10, 8'd10);
        checks++;
        if (pixelData !== 8'h11) begin
            errors++;
            $display("FAIL abort_partial_hi: got %h, required 11", pixelData);
        end
    endtask

    initial begin
        test_reset();
        test_write_swap_read();
        test_out_of_range();
        test_swap_merge();
        test_clear();
        test_swap_during_clear();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
